// File: rtl/pc_hazard_ctrl_if.sv
// Signal bundle between the pipeline datapath and the PC/hazard controller.
// The controller takes the master modport; the datapath side takes the slave modport.
interface pc_hazard_ctrl_if;
    logic [31:0] pc;
    logic [4:0]  id_rs1;
    logic [4:0]  id_rs2;
    logic        id_rs1_used;
    logic        id_rs2_used;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic        ex_redirect;
    logic [31:0] ex_target;
    logic        mem_busy;
    logic        halt_req;
    logic        resume_req;

    logic [31:0] npc;
    logic        data_hazard;
    logic        control_hazard;
    logic        if_id_hold;
    logic        id_ex_hold;
    logic        ex_mem_hold;
    logic        if_id_flush;
    logic        id_ex_flush;
    logic        mem_wb_flush;
    logic        halted;
    logic        misalign_err;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;

    modport master (
        input  pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_redirect, ex_target, mem_busy, halt_req, resume_req,
        output npc, data_hazard, control_hazard, if_id_hold, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, mem_wb_flush, halted, misalign_err,
               stall_cnt, flush_cnt
    );

    modport slave (
        output pc, id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_rd, ex_mem_read,
               ex_redirect, ex_target, mem_busy, halt_req, resume_req,
        input  npc, data_hazard, control_hazard, if_id_hold, id_ex_hold, ex_mem_hold,
               if_id_flush, id_ex_flush, mem_wb_flush, halted, misalign_err,
               stall_cnt, flush_cnt
    );
endinterface

// File: rtl/pc_hazard_ctrl.sv
// Pipeline sequencing controller for the 5-stage RV32 core: next-PC selection,
// load-use stalls, EX redirects, data-memory freeze and debug halt with drain.
module pc_hazard_ctrl #(
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    pc_hazard_ctrl_if.master   bus
);

    localparam logic [1:0] RUN    = 2'd0;
    localparam logic [1:0] DRAIN  = 2'd1;
    localparam logic [1:0] HALTED = 2'd2;
    localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES);

    logic [1:0]  state;
    logic [2:0]  drain_cnt;
    logic [31:0] stall_cnt;
    logic [31:0] flush_cnt;
    logic        misalign_err;
    logic        load_use;

    logic [31:0] npc;
    logic        data_hazard, control_hazard;
    logic        if_id_hold, id_ex_hold, ex_mem_hold;
    logic        if_id_flush, id_ex_flush, mem_wb_flush;
    logic        halted;

    assign load_use = (state == RUN) && bus.ex_mem_read && (bus.ex_rd != 5'd0) &&
                      ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                       (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

    always_comb begin
        // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
        npc            = bus.pc + 32'd4;
        data_hazard    = 1'b0;
        control_hazard = 1'b0;
        if_id_hold     = 1'b0;
        id_ex_hold     = 1'b0;
        ex_mem_hold    = 1'b0;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        mem_wb_flush   = 1'b0;
        halted         = 1'b0;
        if (rst) begin
            npc = RESET_PC;
        end else begin
            halted = (state == HALTED);
            if (bus.mem_busy) begin
                // Whole pipe frozen; a pending redirect is re-presented once memory is ready.
                data_hazard  = 1'b1;
                if_id_hold   = 1'b1;
                id_ex_hold   = 1'b1;
                ex_mem_hold  = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (bus.ex_redirect) begin
                control_hazard = 1'b1;
                if_id_flush    = 1'b1;
                id_ex_flush    = 1'b1;
                npc            = bus.ex_target & 32'hFFFF_FFFE;
            end else if (state != RUN) begin
                data_hazard = 1'b1;
                if_id_flush = 1'b1;
            end else if (load_use) begin
                data_hazard = 1'b1;
                if_id_hold  = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state        <= RUN;
            drain_cnt    <= 3'd0;
            stall_cnt    <= 32'd0;
            flush_cnt    <= 32'd0;
            misalign_err <= 1'b0;
        end else begin
            if (data_hazard)    stall_cnt <= stall_cnt + 32'd1;
            if (control_hazard) flush_cnt <= flush_cnt + 32'd1;
            if (control_hazard && bus.ex_target[1]) misalign_err <= 1'b1;
            if (!bus.mem_busy) begin
                case (state)
                    RUN: if (bus.halt_req) begin
                        state     <= DRAIN;
                        drain_cnt <= DRAIN_INIT;
                    end
                    DRAIN: begin
                        if (drain_cnt <= 3'd1) state <= HALTED;
                        else                   drain_cnt <= drain_cnt - 3'd1;
                    end
                    HALTED: if (bus.resume_req) state <= RUN;
                    default: state <= RUN;
                endcase
            end
        end
    end

    assign bus.npc            = npc;
    assign bus.data_hazard    = data_hazard;
    assign bus.control_hazard = control_hazard;
    assign bus.if_id_hold     = if_id_hold;
    assign bus.id_ex_hold     = id_ex_hold;
    assign bus.ex_mem_hold    = ex_mem_hold;
    assign bus.if_id_flush    = if_id_flush;
    assign bus.id_ex_flush    = id_ex_flush;
    assign bus.mem_wb_flush   = mem_wb_flush;
    assign bus.halted         = halted;
    assign bus.misalign_err   = misalign_err;
    assign bus.stall_cnt      = stall_cnt;
    assign bus.flush_cnt      = flush_cnt;

endmodule

// File: tb/tb_pc_hazard_ctrl.sv
// Self-checking bench for pc_hazard_ctrl: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural reference model.
module tb_pc_hazard_ctrl;
    localparam int          DRAIN = 3;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_err    = 0;

    pc_hazard_ctrl_if bus ();

    pc_hazard_ctrl #(.DRAIN_CYCLES(DRAIN), .RESET_PC(RPC)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference model: halted flag, remaining drain bubbles (0 = not draining), counters.
    bit          m_halted;
    int          m_drain;
    logic [31:0] m_stall;
    logic [31:0] m_flush;
    bit          m_mis;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        rst             = 1'b0;
        bus.pc          = 32'h0;
        bus.id_rs1      = 5'd0;
        bus.id_rs2      = 5'd0;
        bus.id_rs1_used = 1'b0;
        bus.id_rs2_used = 1'b0;
        bus.ex_rd       = 5'd0;
        bus.ex_mem_read = 1'b0;
        bus.ex_redirect = 1'b0;
        bus.ex_target   = 32'h0;
        bus.mem_busy    = 1'b0;
        bus.halt_req    = 1'b0;
        bus.resume_req  = 1'b0;
    endtask

    // Called shortly after a rising edge with inputs already applied; checks the
    // combinational outputs, advances one clock and checks the registered ones.
    task automatic cycle();
        logic [31:0] e_npc;
        bit e_dh, e_ch, e_ifh, e_idh, e_exh, e_iff, e_idf, e_mwf, e_hlt, lu;
        #2;
        e_npc = bus.pc + 32'd4;
        {e_dh, e_ch, e_ifh, e_idh, e_exh, e_iff, e_idf, e_mwf, e_hlt} = '0;
        lu = bus.ex_mem_read && bus.ex_rd != 0 &&
             ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        if (rst) begin
            e_npc = RPC;
        end else begin
            e_hlt = m_halted;
            if (bus.mem_busy) begin
                {e_dh, e_ifh, e_idh, e_exh, e_mwf} = '1;
            end else if (bus.ex_redirect) begin
                {e_ch, e_iff, e_idf} = '1;
                e_npc = {bus.ex_target[31:1], 1'b0};
            end else if (m_halted || m_drain > 0) begin
                {e_dh, e_iff} = '1;
            end else if (lu) begin
                {e_dh, e_ifh, e_idf} = '1;
            end
        end
        check("npc", bus.npc, e_npc);
        check("strobes",
              32'({bus.data_hazard, bus.control_hazard, bus.if_id_hold, bus.id_ex_hold,
                   bus.ex_mem_hold, bus.if_id_flush, bus.id_ex_flush, bus.mem_wb_flush, bus.halted}),
              32'({e_dh, e_ch, e_ifh, e_idh, e_exh, e_iff, e_idf, e_mwf, e_hlt}));
        @(posedge clk);
        if (rst) begin
            m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0; m_mis = 0;
        end else begin
            if (e_dh) m_stall = m_stall + 1;
            if (e_ch) begin
                m_flush = m_flush + 1;
                if (bus.ex_target[1]) m_mis = 1;
            end
            if (!bus.mem_busy) begin
                if (m_halted) begin
                    if (bus.resume_req) m_halted = 0;
                end else if (m_drain > 0) begin
                    m_drain--;
                    if (m_drain == 0) m_halted = 1;
                end else if (bus.halt_req) begin
                    m_drain = DRAIN;
                end
            end
        end
        #1;
        check("stall_cnt", bus.stall_cnt, m_stall);
        check("flush_cnt", bus.flush_cnt, m_flush);
        check("misalign_err", 32'(bus.misalign_err), 32'(m_mis));
    endtask

    initial begin
        int n;
        logic [31:0] s0;
        m_halted = 0; m_drain = 0; m_stall = 0; m_flush = 0; m_mis = 0;
        idle();
        rst = 1'b1;
        @(posedge clk); #1;

        // Reset held for two cycles.
        cycle();
        cycle();
        check("rst_npc", bus.npc, 32'h0);
        check("rst_dh", 32'(bus.data_hazard), 32'd0);
        check("rst_stall_cnt", bus.stall_cnt, 32'd0);
        check("rst_flush_cnt", bus.flush_cnt, 32'd0);

        idle();
        bus.pc = 32'h100;
        #1 check("npc_after_rst", bus.npc, 32'h104);
        cycle();

        // Load-use on rs2.
        bus.ex_mem_read = 1; bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.id_rs2_used = 1;
        #1;
        check("lu_dh", 32'(bus.data_hazard), 32'd1);
        check("lu_if_id_hold", 32'(bus.if_id_hold), 32'd1);
        check("lu_id_ex_flush", 32'(bus.id_ex_flush), 32'd1);
        cycle();
        bus.ex_mem_read = 0; bus.ex_rd = 5'd0;
        #1 check("lu_cleared", 32'(bus.data_hazard), 32'd0);
        cycle();
        check("lu_stall_cnt", bus.stall_cnt, 32'd1);
        bus.ex_mem_read = 1; bus.ex_rd = 5'd0; bus.id_rs2 = 5'd0;
        #1 check("lu_x0_no_stall", 32'(bus.data_hazard), 32'd0);
        cycle();

        // Redirect with a simultaneous load-use match.
        bus.ex_rd = 5'd5; bus.id_rs2 = 5'd5; bus.ex_redirect = 1; bus.ex_target = 32'h2000;
        #1;
        check("redir_ch", 32'(bus.control_hazard), 32'd1);
        check("redir_npc", bus.npc, 32'h2000);
        check("redir_no_dh", 32'(bus.data_hazard), 32'd0);
        cycle();
        check("redir_flush_cnt", bus.flush_cnt, 32'd1);
        idle();
        bus.ex_redirect = 1; bus.ex_target = 32'h2002;
        #1 check("misalign_npc", bus.npc, 32'h2002);
        cycle();
        idle();
        cycle();
        check("misalign_sticky", 32'(bus.misalign_err), 32'd1);

        // mem_busy freezes a pending redirect for three cycles.
        s0 = m_stall;
        bus.pc = 32'h400; bus.ex_redirect = 1; bus.ex_target = 32'h3000; bus.mem_busy = 1;
        for (int i = 0; i < 3; i++) begin
            #1 check("busy_no_ch", 32'(bus.control_hazard), 32'd0);
            cycle();
        end
        bus.mem_busy = 0;
        #1;
        check("busy_redir_ch", 32'(bus.control_hazard), 32'd1);
        check("busy_redir_npc", bus.npc, 32'h3000);
        cycle();
        check("busy_stall_delta", bus.stall_cnt, s0 + 32'd3);

        // Halt latency: one accept cycle plus DRAIN bubbles.
        idle();
        bus.pc = 32'h500; bus.halt_req = 1;
        n = 0;
        while (!bus.halted && n < 20) begin cycle(); n++; end
        check("halt_latency", n, 32'd4);
        bus.halt_req = 0; bus.resume_req = 1;
        cycle();
        check("resume_halted", 32'(bus.halted), 32'd0);
        bus.resume_req = 0;
        #1;
        check("resume_dh", 32'(bus.data_hazard), 32'd0);
        check("resume_npc", bus.npc, 32'h504);
        cycle();

        // Halt with two busy cycles inside the drain.
        bus.halt_req = 1;
        n = 0;
        while (!bus.halted && n < 20) begin
            bus.mem_busy = (n == 2 || n == 3);
            cycle();
            n++;
        end
        check("halt_busy_latency", n, 32'd6);
        idle();
        bus.resume_req = 1;
        cycle();
        idle();

        // PC wrap.
        bus.pc = 32'hFFFF_FFFC;
        #1 check("wrap_npc", bus.npc, 32'h0);
        cycle();

        // Reset while halted.
        bus.halt_req = 1;
        for (int i = 0; i < 4; i++) cycle();
        check("pre_rst_halted", 32'(bus.halted), 32'd1);
        bus.halt_req = 0; rst = 1;
        cycle();
        rst = 0;
        #1;
        check("rst_halted_cleared", 32'(bus.halted), 32'd0);
        check("rst_halted_run", 32'(bus.data_hazard), 32'd0);
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            rst             = ($urandom_range(0, 59) == 0);
            bus.pc          = $urandom();
            bus.id_rs1      = 5'($urandom_range(0, 3));
            bus.id_rs2      = 5'($urandom_range(0, 3));
            bus.id_rs1_used = 1'($urandom_range(0, 1));
            bus.id_rs2_used = 1'($urandom_range(0, 1));
            bus.ex_rd       = 5'($urandom_range(0, 3));
            bus.ex_mem_read = 1'($urandom_range(0, 1));
            bus.ex_redirect = ($urandom_range(0, 6) == 0);
            bus.ex_target   = $urandom();
            bus.mem_busy    = ($urandom_range(0, 4) == 0);
            bus.resume_req  = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) == 0) bus.halt_req = ~bus.halt_req;
            cycle();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
